// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus host arbiter.
package bus_arb_pkg;

  // Arbitration FSM: ArbIdle picks a fresh winner each cycle, ArbHold keeps
  // presenting a request the device has not accepted yet.
  typedef enum logic {
    ArbIdle = 1'b0,
    ArbHold = 1'b1
  } arb_state_e;

  // Width needed to hold a host index, never less than one bit.
  function automatic int id_width(input int nr_hosts);
    return (nr_hosts > 1) ? $clog2(nr_hosts) : 1;
  endfunction

endpackage

// File: rtl/bus_host_arbiter_if.sv
// Host-side and device-side req/gnt/rvalid signals of the bus host arbiter.
interface bus_host_arbiter_if #(
  parameter int NrHosts   = 2,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);

  // Host side, one slice per requester
  logic [NrHosts-1:0]             host_req_i;
  logic [NrHosts-1:0]             host_gnt_o;
  logic [NrHosts*AddrWidth-1:0]   host_addr_i;
  logic [NrHosts-1:0]             host_we_i;
  logic [NrHosts*DataWidth/8-1:0] host_be_i;
  logic [NrHosts*DataWidth-1:0]   host_wdata_i;
  logic [NrHosts-1:0]             host_rvalid_o;
  logic [DataWidth-1:0]           host_rdata_o;
  logic [NrHosts-1:0]             host_err_o;

  // Device side, towards the crossbar input
  logic                   dev_req_o;
  logic                   dev_gnt_i;
  logic [AddrWidth-1:0]   dev_addr_o;
  logic                   dev_we_o;
  logic [DataWidth/8-1:0] dev_be_o;
  logic [DataWidth-1:0]   dev_wdata_o;
  logic                   dev_rvalid_i;
  logic [DataWidth-1:0]   dev_rdata_i;
  logic                   dev_err_i;

  // Sticky status
  logic spurious_rsp_o;

  // The arbiter itself
  modport master (
    input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    output dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
    input  dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i,
    output spurious_rsp_o
  );

  // The surrounding hosts and device
  modport slave (
    output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    input  dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
    output dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i,
    input  spurious_rsp_o
  );

endinterface

// File: rtl/bus_arb_id_fifo.sv
// In-order FIFO of host IDs for transactions accepted by the device but not
// yet answered. Head is the host that owns the next response.
module bus_arb_id_fifo #(
  parameter int Depth = 2,
  parameter int Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers and occupancy; a simultaneous push and pop leaves count alone
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset, occupancy decides what is valid
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid device port between several
// hosts, routing responses back in order through an ID FIFO.
module bus_host_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NrHosts        = 2,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 2
) (
  input logic                clk_i,
  input logic                rst_ni,
  bus_host_arbiter_if.master bus
);

  localparam int IdW = id_width(NrHosts);
  localparam int BeW = DataWidth / 8;

  arb_state_e       state;
  arb_state_e       state_next;
  logic [IdW-1:0]   locked;
  logic [IdW-1:0]   locked_next;
  logic [IdW-1:0]   ptr;
  logic [IdW-1:0]   winner;
  logic [IdW-1:0]   sel;
  logic [IdW-1:0]   head;
  logic             found;
  int               idx;
  logic             pending;
  logic             dev_req;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             spurious;

  logic [NrHosts-1:0]   gnt_vec;
  logic [NrHosts-1:0]   rvalid_vec;
  logic [NrHosts-1:0]   err_vec;
  logic [DataWidth-1:0] rdata;
  logic [AddrWidth-1:0] addr;
  logic                 we;
  logic [BeW-1:0]       be;
  logic [DataWidth-1:0] wdata;

  // Round-robin search: first requesting host at or after the pointer
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NrHosts; i++) begin
      idx = (int'(ptr) + i) % NrHosts;
      if (!found && bus.host_req_i[idx]) begin
        winner = IdW'(idx);
        found  = 1'b1;
      end
    end
  end

  // Next-state logic; in ArbHold the selection is frozen on the locked host
  always_comb begin
    state_next  = state;
    locked_next = locked;
    sel         = winner;
    pending     = 1'b0;
    case (state)
      ArbIdle: begin
        sel     = winner;
        pending = |bus.host_req_i;
      end
      ArbHold: begin
        sel     = locked;
        pending = bus.host_req_i[locked];
      end
      default: begin
        sel     = winner;
        pending = 1'b0;
      end
    endcase
    pending = pending && rst_ni;
    dev_req = pending && !fifo_full;
    push    = dev_req && bus.dev_gnt_i;
    case (state)
      ArbIdle: begin
        if (dev_req && !bus.dev_gnt_i) begin
          state_next  = ArbHold;
          locked_next = winner;
        end
      end
      ArbHold: begin
        if (push || !bus.host_req_i[locked]) state_next = ArbIdle;
      end
      default: state_next = ArbIdle;
    endcase
  end

  // Request payload and grant/response steering towards the hosts
  always_comb begin
    addr       = '0;
    we         = 1'b0;
    be         = '0;
    wdata      = '0;
    gnt_vec    = '0;
    rvalid_vec = '0;
    err_vec    = '0;
    rdata      = '0;
    if (pending) begin
      addr  = bus.host_addr_i[int'(sel)*AddrWidth +: AddrWidth];
      we    = bus.host_we_i[sel];
      be    = bus.host_be_i[int'(sel)*BeW +: BeW];
      wdata = bus.host_wdata_i[int'(sel)*DataWidth +: DataWidth];
    end
    gnt_vec[sel] = push;
    if (pop) begin
      rvalid_vec[head] = 1'b1;
      err_vec[head]    = bus.dev_err_i;
      rdata            = bus.dev_rdata_i;
    end
  end

  assign pop = bus.dev_rvalid_i && !fifo_empty;

  // FSM state and locked host register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= ArbIdle;
      locked <= '0;
    end else begin
      state  <= state_next;
      locked <= locked_next;
    end
  end

  // Priority moves just past the host that was granted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr <= '0;
    end else if (push) begin
      ptr <= (sel == IdW'(NrHosts - 1)) ? '0 : sel + 1'b1;
    end
  end

  // Sticky flag for a device response arriving with nothing outstanding
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spurious <= 1'b0;
    end else if (bus.dev_rvalid_i && fifo_empty) begin
      spurious <= 1'b1;
    end
  end

  bus_arb_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdW)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .pop    (pop),
    .wdata  (sel),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign bus.dev_req_o      = dev_req;
  assign bus.dev_addr_o     = addr;
  assign bus.dev_we_o       = we;
  assign bus.dev_be_o       = be;
  assign bus.dev_wdata_o    = wdata;
  assign bus.host_gnt_o     = gnt_vec;
  assign bus.host_rvalid_o  = rvalid_vec;
  assign bus.host_err_o     = err_vec;
  assign bus.host_rdata_o   = rdata;
  assign bus.spurious_rsp_o = spurious;

  gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_vec));
  rvalid_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rvalid_vec));
  no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && fifo_full));

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Self-checking bench for bus_host_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_bus_host_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bus_host_arbiter_if #(.NrHosts(N), .AddrWidth(AW), .DataWidth(DW)) bus ();

  bus_host_arbiter #(
    .NrHosts        (N),
    .AddrWidth      (AW),
    .DataWidth      (DW),
    .MaxOutstanding (MO)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: priority pointer, outstanding host IDs in issue
  // order, locked host (-1 when none) and the sticky spurious flag
  int m_ptr;
  int m_q[$];
  int m_locked;
  bit m_spur;
  int m_sel;
  bit m_gnt_now;

  logic [N-1:0]  exp_gnt, exp_rvalid, exp_err;
  logic          exp_dev_req, exp_we, exp_spur;
  logic [AW-1:0] exp_addr;
  logic [BW-1:0] exp_be;
  logic [DW-1:0] exp_wdata, exp_rdata;

  task automatic set_host(input int h, input bit req, input logic [AW-1:0] addr,
                          input bit we, input logic [BW-1:0] be, input logic [DW-1:0] wdata);
    bus.host_req_i[h]              = req;
    bus.host_addr_i[h*AW +: AW]    = addr;
    bus.host_we_i[h]               = we;
    bus.host_be_i[h*BW +: BW]      = be;
    bus.host_wdata_i[h*DW +: DW]   = wdata;
  endtask

  task automatic set_dev(input bit gnt, input bit rvalid, input bit err, input logic [DW-1:0] rdata);
    bus.dev_gnt_i    = gnt;
    bus.dev_rvalid_i = rvalid;
    bus.dev_err_i    = err;
    bus.dev_rdata_i  = rdata;
  endtask

  task automatic model_reset();
    m_ptr    = 0;
    m_locked = -1;
    m_spur   = 1'b0;
    m_q.delete();
  endtask

  // Expected outputs for the inputs currently applied
  task automatic model_eval();
    int  sel;
    int  idx;
    bit  found;
    bit  pend;
    sel   = 0;
    found = 1'b0;
    if (m_locked >= 0) begin
      sel  = m_locked;
      pend = bus.host_req_i[m_locked];
    end else begin
      pend = |bus.host_req_i;
      for (int i = 0; i < N; i++) begin
        idx = (m_ptr + i) % N;
        if (!found && bus.host_req_i[idx]) begin
          sel   = idx;
          found = 1'b1;
        end
      end
    end
    m_sel       = sel;
    exp_dev_req = pend && (m_q.size() < MO);
    exp_addr    = pend ? bus.host_addr_i[sel*AW +: AW] : '0;
    exp_we      = pend ? bus.host_we_i[sel] : 1'b0;
    exp_be      = pend ? bus.host_be_i[sel*BW +: BW] : '0;
    exp_wdata   = pend ? bus.host_wdata_i[sel*DW +: DW] : '0;
    m_gnt_now   = exp_dev_req && bus.dev_gnt_i;
    exp_gnt     = m_gnt_now ? N'(1 << sel) : '0;
    if (bus.dev_rvalid_i && m_q.size() > 0) begin
      exp_rvalid = N'(1 << m_q[0]);
      exp_err    = bus.dev_err_i ? exp_rvalid : '0;
      exp_rdata  = bus.dev_rdata_i;
    end else begin
      exp_rvalid = '0;
      exp_err    = '0;
      exp_rdata  = '0;
    end
    exp_spur = m_spur;
  endtask

  // State the model holds after the coming clock edge
  task automatic model_commit();
    if (bus.dev_rvalid_i) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else m_spur = 1'b1;
    end
    if (m_gnt_now) begin
      m_q.push_back(m_sel);
      m_ptr    = (m_sel + 1) % N;
      m_locked = -1;
    end else if (exp_dev_req) begin
      m_locked = m_sel;
    end else if (m_locked >= 0 && !bus.host_req_i[m_locked]) begin
      m_locked = -1;
    end
  endtask

  task automatic settle();
    #4;
    model_eval();
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int h = 0; h < N; h++) set_host(h, 1'b0, '0, 1'b0, '0, '0);
    set_dev(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    set_host(0, 1'b1, 32'h1000_0000, 1'b1, 4'hF, 32'h1234_5678);
    set_host(1, 1'b1, 32'h2000_0000, 1'b0, 4'h3, 32'h8765_4321);
    set_dev(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    #4;
    n_checks++; if (bus.dev_req_o !== 1'b0) $display("[TB] FAIL rst_dev_req got %b want 0", bus.dev_req_o); else n_pass++;
    n_checks++; if (bus.host_gnt_o !== 2'b00) $display("[TB] FAIL rst_gnt got %b want 00", bus.host_gnt_o); else n_pass++;
    n_checks++; if (bus.dev_addr_o !== 32'h0) $display("[TB] FAIL rst_addr got %h want 0", bus.dev_addr_o); else n_pass++;
    n_checks++; if (bus.host_rvalid_o !== 2'b00 || bus.host_rdata_o !== 32'h0) $display("[TB] FAIL rst_rsp got %b/%h want 00/0", bus.host_rvalid_o, bus.host_rdata_o); else n_pass++;
    n_checks++; if (bus.spurious_rsp_o !== 1'b0) $display("[TB] FAIL rst_spur got %b want 0", bus.spurious_rsp_o); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b1;
    model_reset();
    settle();
    n_checks++; if (bus.dev_req_o !== 1'b0 || bus.dev_addr_o !== 32'h0) $display("[TB] FAIL idle_out got %b/%h want 0/0", bus.dev_req_o, bus.dev_addr_o); else n_pass++;
    advance();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] want_gnt, want_rv;
    for (int k = 0; k < 6; k++) begin
      set_host(0, 1'b1, 32'h1000_0000, 1'b0, 4'hF, 32'h0);
      set_host(1, 1'b1, 32'h2000_0000, 1'b0, 4'hF, 32'h0);
      set_dev(1'b1, k > 0, 1'b0, 32'hA000_0000 | ((k + 1) % 2));
      settle();
      want_gnt = N'(1 << (k % 2));
      want_rv  = N'(1 << ((k + 1) % 2));
      n_checks++; if (bus.host_gnt_o !== want_gnt) $display("[TB] FAIL rr_gnt k=%0d got %b want %b", k, bus.host_gnt_o, want_gnt); else n_pass++;
      n_checks++; if (bus.dev_addr_o !== ((k % 2) ? 32'h2000_0000 : 32'h1000_0000)) $display("[TB] FAIL rr_addr k=%0d got %h", k, bus.dev_addr_o); else n_pass++;
      if (k > 0) begin
        n_checks++; if (bus.host_rvalid_o !== want_rv) $display("[TB] FAIL rr_rvalid k=%0d got %b want %b", k, bus.host_rvalid_o, want_rv); else n_pass++;
        n_checks++; if (bus.host_rdata_o !== (32'hA000_0000 | ((k + 1) % 2))) $display("[TB] FAIL rr_rdata k=%0d got %h", k, bus.host_rdata_o); else n_pass++;
      end
      advance();
    end
    idle_inputs();
    set_dev(1'b0, 1'b1, 1'b0, 32'hA000_0001);
    settle();
    n_checks++; if (bus.host_rvalid_o !== 2'b10 || bus.host_rdata_o !== 32'hA000_0001) $display("[TB] FAIL rr_drain got %b/%h want 10/a0000001", bus.host_rvalid_o, bus.host_rdata_o); else n_pass++;
    advance();
  endtask

  task automatic test_hold();
    idle_inputs();
    for (int c = 1; c <= 3; c++) begin
      set_host(1, 1'b1, 32'h2222_0000, 1'b1, 4'h3, 32'hDEAD_0001);
      set_host(0, c >= 2, 32'h1111_0000, 1'b0, 4'hF, 32'hBEEF_0000);
      set_dev(1'b0, 1'b0, 1'b0, '0);
      settle();
      n_checks++; if (bus.dev_req_o !== 1'b1 || bus.dev_addr_o !== 32'h2222_0000 || bus.dev_we_o !== 1'b1) $display("[TB] FAIL hold_sel c=%0d got %b/%h want 1/22220000", c, bus.dev_req_o, bus.dev_addr_o); else n_pass++;
      n_checks++; if (bus.host_gnt_o !== 2'b00) $display("[TB] FAIL hold_gnt c=%0d got %b want 00", c, bus.host_gnt_o); else n_pass++;
      advance();
    end
    set_dev(1'b1, 1'b0, 1'b0, '0);
    settle();
    n_checks++; if (bus.host_gnt_o !== 2'b10 || bus.dev_addr_o !== 32'h2222_0000) $display("[TB] FAIL hold_grant got %b/%h want 10/22220000", bus.host_gnt_o, bus.dev_addr_o); else n_pass++;
    advance();
    set_host(1, 1'b0, '0, 1'b0, '0, '0);
    settle();
    n_checks++; if (bus.host_gnt_o !== 2'b01 || bus.dev_addr_o !== 32'h1111_0000) $display("[TB] FAIL hold_next got %b/%h want 01/11110000", bus.host_gnt_o, bus.dev_addr_o); else n_pass++;
    advance();
    idle_inputs();
    set_dev(1'b0, 1'b1, 1'b0, 32'h5);
    settle();
    n_checks++; if (bus.host_rvalid_o !== 2'b10) $display("[TB] FAIL hold_rsp1 got %b want 10", bus.host_rvalid_o); else n_pass++;
    advance();
    settle();
    n_checks++; if (bus.host_rvalid_o !== 2'b01) $display("[TB] FAIL hold_rsp2 got %b want 01", bus.host_rvalid_o); else n_pass++;
    advance();
  endtask

  task automatic test_fifo_full();
    logic [N-1:0] want_gnt [5];
    logic         want_req [5];
    want_gnt = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b10};
    want_req = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 5; c++) begin
      set_host(0, 1'b1, 32'h3000_0000, 1'b0, 4'hF, 32'h0);
      set_host(1, 1'b1, 32'h4000_0000, 1'b1, 4'hF, 32'h1);
      set_dev(1'b1, c == 3, 1'b0, 32'h77);
      settle();
      n_checks++; if (bus.dev_req_o !== want_req[c]) $display("[TB] FAIL full_req c=%0d got %b want %b", c, bus.dev_req_o, want_req[c]); else n_pass++;
      n_checks++; if (bus.host_gnt_o !== want_gnt[c]) $display("[TB] FAIL full_gnt c=%0d got %b want %b", c, bus.host_gnt_o, want_gnt[c]); else n_pass++;
      if (c == 3) begin
        n_checks++; if (bus.host_rvalid_o !== 2'b10) $display("[TB] FAIL full_pop got %b want 10", bus.host_rvalid_o); else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_push_pop();
    idle_inputs();
    set_dev(1'b0, 1'b1, 1'b0, 32'h11);
    settle();
    n_checks++; if (bus.host_rvalid_o !== 2'b01) $display("[TB] FAIL pp_drain got %b want 01", bus.host_rvalid_o); else n_pass++;
    advance();
    set_host(0, 1'b1, 32'h5000_0000, 1'b0, 4'hF, 32'h0);
    set_dev(1'b1, 1'b1, 1'b0, 32'h22);
    settle();
    n_checks++; if (bus.host_gnt_o !== 2'b01 || bus.host_rvalid_o !== 2'b10) $display("[TB] FAIL pp_same got gnt %b rv %b want 01/10", bus.host_gnt_o, bus.host_rvalid_o); else n_pass++;
    advance();
    idle_inputs();
    set_dev(1'b0, 1'b1, 1'b0, 32'h33);
    settle();
    n_checks++; if (bus.host_rvalid_o !== 2'b01 || bus.host_rdata_o !== 32'h33) $display("[TB] FAIL pp_newhead got %b/%h want 01/33", bus.host_rvalid_o, bus.host_rdata_o); else n_pass++;
    advance();
  endtask

  task automatic test_err_spurious();
    idle_inputs();
    set_host(1, 1'b1, 32'h6000_0000, 1'b0, 4'hF, 32'h0);
    set_dev(1'b1, 1'b0, 1'b0, '0);
    settle();
    n_checks++; if (bus.host_gnt_o !== 2'b10) $display("[TB] FAIL err_gnt got %b want 10", bus.host_gnt_o); else n_pass++;
    advance();
    idle_inputs();
    set_dev(1'b0, 1'b1, 1'b1, 32'hE);
    settle();
    n_checks++; if (bus.host_rvalid_o !== 2'b10 || bus.host_err_o !== 2'b10) $display("[TB] FAIL err_rsp got rv %b err %b want 10/10", bus.host_rvalid_o, bus.host_err_o); else n_pass++;
    advance();
    set_dev(1'b0, 1'b1, 1'b0, 32'hF);
    settle();
    n_checks++; if (bus.host_rvalid_o !== 2'b00 || bus.spurious_rsp_o !== 1'b0) $display("[TB] FAIL spur_rsp got rv %b spur %b want 00/0", bus.host_rvalid_o, bus.spurious_rsp_o); else n_pass++;
    advance();
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      settle();
      n_checks++; if (bus.spurious_rsp_o !== 1'b1) $display("[TB] FAIL spur_sticky c=%0d got %b want 1", c, bus.spurious_rsp_o); else n_pass++;
      advance();
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    set_host(0, 1'b1, 32'h7000_0000, 1'b0, 4'hF, 32'h0);
    set_dev(1'b1, 1'b0, 1'b0, '0);
    settle();
    n_checks++; if (bus.host_gnt_o !== 2'b01) $display("[TB] FAIL mid_gnt0 got %b want 01", bus.host_gnt_o); else n_pass++;
    advance();
    set_host(0, 1'b0, '0, 1'b0, '0, '0);
    set_host(1, 1'b1, 32'h8000_0000, 1'b0, 4'hF, 32'h0);
    set_dev(1'b0, 1'b0, 1'b0, '0);
    settle();
    n_checks++; if (bus.dev_req_o !== 1'b1 || bus.host_gnt_o !== 2'b00) $display("[TB] FAIL mid_hold got %b/%b want 1/00", bus.dev_req_o, bus.host_gnt_o); else n_pass++;
    advance();
    rst_n = 1'b0;
    set_host(0, 1'b1, 32'h7000_0000, 1'b0, 4'hF, 32'h0);
    set_dev(1'b1, 1'b1, 1'b0, 32'h9);
    #1;
    n_checks++; if (bus.dev_req_o !== 1'b0 || bus.dev_addr_o !== 32'h0 || bus.host_gnt_o !== 2'b00 || bus.host_rvalid_o !== 2'b00) $display("[TB] FAIL mid_rst got req %b addr %h gnt %b rv %b want all 0", bus.dev_req_o, bus.dev_addr_o, bus.host_gnt_o, bus.host_rvalid_o); else n_pass++;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_inputs();
    set_dev(1'b0, 1'b1, 1'b0, 32'h9);
    settle();
    n_checks++; if (bus.host_rvalid_o !== 2'b00 || bus.spurious_rsp_o !== 1'b0) $display("[TB] FAIL mid_late got rv %b spur %b want 00/0", bus.host_rvalid_o, bus.spurious_rsp_o); else n_pass++;
    advance();
    set_host(0, 1'b1, 32'h7000_0000, 1'b0, 4'hF, 32'h0);
    set_host(1, 1'b1, 32'h8000_0000, 1'b0, 4'hF, 32'h0);
    set_dev(1'b1, 1'b0, 1'b0, '0);
    settle();
    n_checks++; if (bus.host_gnt_o !== 2'b01 || bus.spurious_rsp_o !== 1'b1) $display("[TB] FAIL mid_regrant got gnt %b spur %b want 01/1", bus.host_gnt_o, bus.spurious_rsp_o); else n_pass++;
    advance();
    idle_inputs();
    set_dev(1'b0, 1'b1, 1'b0, 32'hA);
    settle();
    n_checks++; if (bus.host_rvalid_o !== 2'b01) $display("[TB] FAIL mid_drain got %b want 01", bus.host_rvalid_o); else n_pass++;
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int h = 0; h < N; h++)
        set_host(h, $urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 1), BW'($urandom), $urandom);
      set_dev($urandom_range(0, 1), $urandom_range(0, 99) < 40, $urandom_range(0, 1), $urandom);
      settle();
      n_checks++; if (bus.dev_req_o !== exp_dev_req) $display("[TB] FAIL rnd_req c=%0d got %b want %b", c, bus.dev_req_o, exp_dev_req); else n_pass++;
      n_checks++; if (bus.host_gnt_o !== exp_gnt) $display("[TB] FAIL rnd_gnt c=%0d got %b want %b", c, bus.host_gnt_o, exp_gnt); else n_pass++;
      n_checks++; if (bus.dev_addr_o !== exp_addr || bus.dev_we_o !== exp_we || bus.dev_be_o !== exp_be || bus.dev_wdata_o !== exp_wdata)
        $display("[TB] FAIL rnd_payload c=%0d got %h/%b/%h/%h want %h/%b/%h/%h", c, bus.dev_addr_o, bus.dev_we_o, bus.dev_be_o, bus.dev_wdata_o, exp_addr, exp_we, exp_be, exp_wdata);
      else n_pass++;
      n_checks++; if (bus.host_rvalid_o !== exp_rvalid || bus.host_err_o !== exp_err) $display("[TB] FAIL rnd_rsp c=%0d got %b/%b want %b/%b", c, bus.host_rvalid_o, bus.host_err_o, exp_rvalid, exp_err); else n_pass++;
      if (exp_rvalid != '0) begin
        n_checks++; if (bus.host_rdata_o !== exp_rdata) $display("[TB] FAIL rnd_rdata c=%0d got %h want %h", c, bus.host_rdata_o, exp_rdata); else n_pass++;
      end
      n_checks++; if (bus.spurious_rsp_o !== exp_spur) $display("[TB] FAIL rnd_spur c=%0d got %b want %b", c, bus.spurious_rsp_o, exp_spur); else n_pass++;
      advance();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_hold();
    test_fifo_full();
    test_push_pop();
    test_err_spurious();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
